// File: rtl/fft_job_arbiter.sv
// Round-robin arbiter that time-shares one FFT core among NREQ requesters:
// grants a job, pulses the core start, waits for done under a watchdog, then returns a response.
module fft_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [SEL_W-1:0]  in_sel,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [15:0]       jobs_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  owner_q, last_q, grant;
  logic [NREQ-1:0]   grant_oh, owner_oh;
  logic              any_req;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              rsp_err_q, busy_q, tmo_q;
  logic [15:0]       jobs_q;
  logic              hit_done, hit_tmo, rsp_hs;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    int idx;
    logic [NREQ-1:0] req_sh;
    any_req = 1'b0;
    grant   = last_q;
    idx     = 0;
    req_sh  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx    = (int'(last_q) + i) % NREQ;
      req_sh = req_valid >> idx;
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        grant   = SEL_W'(idx);
      end
    end
  end

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    fft_start = 1'b0;
    hit_done  = 1'b0;
    hit_tmo   = 1'b0;
    rsp_hs    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No handshake may complete while reset is held.
        if (any_req && rst) begin
          req_ready = grant_oh;
          state_d   = START;
        end
      end
      START: begin
        fft_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // A done arriving on the terminal count beats the watchdog.
        if (fft_done) begin
          hit_done = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          hit_tmo = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (|(rsp_ready & owner_oh)) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= SEL_W'(NREQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (state_q == IDLE && any_req) begin
        owner_q <= grant;
        last_q  <= grant;
      end
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (hit_done || hit_tmo) begin
        rsp_valid_q <= owner_oh;
        rsp_err_q   <= hit_tmo;
      end else if (rsp_hs) begin
        rsp_valid_q <= '0;
        rsp_err_q   <= 1'b0;
      end
      if (hit_done) begin
        jobs_q <= jobs_q + 16'd1;
      end
      if (hit_tmo) begin
        tmo_q <= 1'b1;
      end else if (err_clr) begin
        tmo_q <= 1'b0;
      end
    end
  end

  assign in_sel      = owner_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Transaction-level bench for fft_job_arbiter: each job's grant, latency, outcome
// and counters are predicted from round-robin and watchdog rules.
module tb_fft_job_arbiter;

  localparam int NREQ    = 4;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic              fft_start;
  logic              fft_done;
  logic [SEL_W-1:0]  in_sel;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_err;
  logic [NREQ-1:0]   rsp_ready;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;
  logic [15:0]       jobs_done;

  int   checks;
  int   errors;
  int   exp_last;
  int   exp_sel;
  int   exp_jobs;
  logic exp_tmo;

  fft_job_arbiter #(
    .NREQ(NREQ), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .fft_start(fft_start), .fft_done(fft_done),
    .in_sel(in_sel),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_reset();
    exp_last = NREQ - 1;
    exp_sel  = 0;
    exp_jobs = 0;
    exp_tmo  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit force_done);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'(1'b0));
      chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("idle_in_sel", 32'(in_sel), 32'(exp_sel));
      chk("idle_tmo", 32'(timeout_err), 32'(exp_tmo));
      fft_done = force_done ? 1'b1 : 1'($urandom_range(1, 0));
      err_clr  = ($urandom_range(3, 0) == 0);
      if (err_clr) exp_tmo = 1'b0;
    end
  endtask

  // d = WAIT cycle on which fft_done is raised; d > TIMEOUT means never.
  task automatic run_job(input logic [NREQ-1:0] mask, input int d,
                         input bit clr_on_tmo, input int rdly);
    int g;
    int e;
    bit tmo;
    g   = rr_pick(mask, exp_last);
    tmo = (d > TIMEOUT);
    e   = tmo ? TIMEOUT : d;

    @(negedge clk);
    fft_done  = 1'b0;
    err_clr   = 1'b0;
    req_valid = mask;
    #1;
    chk("req_ready", 32'(req_ready), 32'(onehot(g)));
    chk("busy_pre", 32'(busy), 32'(1'b0));

    @(negedge clk);
    req_valid = mask & ~onehot(g);
    #1;
    chk("start_pulse", 32'(fft_start), 32'(1'b1));
    chk("start_in_sel", 32'(in_sel), 32'(g));
    chk("start_busy", 32'(busy), 32'(1'b1));
    chk("start_req_ready", 32'(req_ready), 32'(0));

    for (int k = 1; k <= e; k++) begin
      @(negedge clk);
      fft_done = (!tmo && k == d);
      err_clr  = (tmo && clr_on_tmo && k == TIMEOUT);
      #1;
      if (k == 1) chk("start_once", 32'(fft_start), 32'(1'b0));
      if (k == e) chk("rsp_early", 32'(rsp_valid), 32'(0));
    end

    if (tmo) exp_tmo = 1'b1;
    else     exp_jobs++;
    exp_last = g;
    exp_sel  = g;

    @(negedge clk);
    fft_done = 1'b1;
    err_clr  = 1'b0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(onehot(g)));
    chk("rsp_err", 32'(rsp_err), 32'(tmo));
    chk("rsp_in_sel", 32'(in_sel), 32'(g));
    chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));
    chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));

    for (int r = 0; r <= rdly; r++) begin
      if (r > 0) begin
        @(negedge clk);
        #1;
        chk("rsp_hold", 32'(rsp_valid), 32'(onehot(g)));
        chk("rsp_err_hold", 32'(rsp_err), 32'(tmo));
      end
      rsp_ready = (r == rdly) ? onehot(g) : (NREQ'($urandom) & ~onehot(g));
    end

    @(negedge clk);
    rsp_ready = '0;
    req_valid = '0;
    fft_done  = 1'b0;
    #1;
    chk("post_busy", 32'(busy), 32'(1'b0));
    chk("post_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("post_rsp_err", 32'(rsp_err), 32'(1'b0));
    chk("post_jobs", 32'(jobs_done), 32'(exp_jobs));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    req_valid = '0;
    fft_done  = 1'b0;
    rsp_ready = '0;
    err_clr   = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_start", 32'(fft_start), 32'(1'b0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_in_sel", 32'(in_sel), 32'(0));
    chk("rst_jobs", 32'(jobs_done), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_job(4'b0001, 10, 1'b0, 0);
    for (int j = 0; j < 5; j++) run_job(4'b1111, 1, 1'b0, 0);
    run_job(4'b0010, 3, 1'b0, 1);
    run_job(4'b1001, 2, 1'b0, 0);
    run_job(4'b1001, 2, 1'b0, 0);

    run_job(4'b0100, TIMEOUT + 100, 1'b0, 2);
    @(negedge clk);
    err_clr = 1'b1;
    exp_tmo = 1'b0;
    idle_cycles(1, 1'b0);

    run_job(4'b1000, TIMEOUT, 1'b0, 0);
    run_job(4'b0001, TIMEOUT + 1, 1'b1, 1);
    idle_cycles(3, 1'b1);

    for (int j = 0; j < 40; j++) begin
      run_job(NREQ'($urandom_range(15, 1)), $urandom_range(70, 1),
              1'($urandom_range(1, 0)), $urandom_range(3, 0));
      idle_cycles($urandom_range(2, 0), 1'b0);
    end

    @(negedge clk);
    err_clr   = 1'b0;
    fft_done  = 1'b0;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0110;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'(1'b0));
    chk("mid_rst_start", 32'(fft_start), 32'(1'b0));
    chk("mid_rst_tmo", 32'(timeout_err), 32'(1'b0));
    chk("mid_rst_jobs", 32'(jobs_done), 32'(0));
    chk("mid_rst_in_sel", 32'(in_sel), 32'(0));
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    model_reset();
    idle_cycles(1, 1'b0);
    run_job(4'b0100, 5, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
